// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate/target generator; define IMM_GEN_SKID_EN for a two-entry skid buffer with registered in_ready
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [2:0]      in_imm_sel,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic [2:0]      out_sel,
    output logic            out_illegal
);
    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] tgt;
        logic [2:0]      sel;
        logic            ill;
    } entry_t;
    logic [31:0] v32;
    logic [XLEN-1:0] imm_x;
    entry_t new_e, m_q, m_d;
    logic m_valid_q, m_valid_d, accept;
    logic unused_inst;
    assign unused_inst = ^in_inst[6:0];
    // zero-extended formats keep bit 31 clear, so one sign extension serves every format
    always_comb begin
        v32 = in_imm_sel == 3'd0 ? {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]} :
              in_imm_sel == 3'd1 ? {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0} :
              in_imm_sel == 3'd2 ? {in_inst[31:12], 12'b0} :
              in_imm_sel == 3'd3 ? {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0} :
              in_imm_sel == 3'd4 ? {{20{in_inst[31]}}, in_inst[31:20]} :
              in_imm_sel == 3'd5 ? (XLEN == 64 ? {26'b0, in_inst[25:20]} : {27'b0, in_inst[24:20]}) :
              in_imm_sel == 3'd6 ? {27'b0, in_inst[19:15]} : 32'b0;
        imm_x = XLEN'($signed(v32));
        new_e.imm = imm_x;
        new_e.tgt = in_pc + imm_x;
        new_e.sel = in_imm_sel;
        new_e.ill = in_imm_sel == 3'd7;
    end
    assign accept = in_valid && in_ready;
`ifdef IMM_GEN_SKID_EN
    entry_t s_q, s_d;
    logic s_valid_q, s_valid_d, rdy_q, free;
    assign in_ready = rdy_q && !reset;
    always_comb begin
        free = !m_valid_q || out_ready;
        m_d = free ? (s_valid_q ? s_q : (accept ? new_e : m_q)) : m_q;
        m_valid_d = !flush && (free ? (s_valid_q || accept) : 1'b1);
        s_d = accept ? new_e : s_q;
        s_valid_d = !flush && (free ? (s_valid_q && accept) : (s_valid_q || accept));
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_q <= '0;
            s_valid_q <= 1'b0;
            s_q <= '0;
            rdy_q <= 1'b1;
        end else begin
            m_valid_q <= m_valid_d;
            m_q <= m_d;
            s_valid_q <= s_valid_d;
            s_q <= s_d;
            rdy_q <= !s_valid_d;
        end
    end
`else
    assign in_ready = !reset && (!m_valid_q || out_ready);
    always_comb begin
        m_valid_d = flush ? 1'b0 : accept ? 1'b1 : (m_valid_q && !out_ready);
        m_d = accept ? new_e : m_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_q <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_q <= m_d;
        end
    end
`endif
    assign out_valid = m_valid_q;
    assign out_imm = m_q.imm;
    assign out_target = m_q.tgt;
    assign out_sel = m_q.sel;
    assign out_illegal = m_q.ill;
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator for the decode stage. Accepts an instruction, immediate-format select and PC through a valid/ready handshake. Produces the sign/zero-extended XLEN-wide immediate and the PC-relative target (pc + imm) one cycle later. Sits between fetch and the decode/branch-target logic, replacing the purely combinational immediate path so the immediate adder is off the decode critical path.

## Interface
- XLEN, 32: datapath width. Legal values are 32 and 64.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all buffered entries (branch mispredict).
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block can accept this cycle.
- in_inst  in  32  raw instruction word.
- in_imm_sel  in  3  format: 0=S, 1=B, 2=U, 3=J, 4=I, 5=I_star (shamt), 6=Z (CSR uimm), 7=illegal.
- in_pc  in  XLEN  PC of in_inst.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  generated immediate.
- out_target  out  XLEN  in_pc + out_imm, modulo 2^XLEN.
- out_sel  out  3  echo of in_imm_sel.
- out_illegal  out  1  set when sel = 7.

## Operation
- Transfers: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
- Immediate formats, with sign extension from inst[31] to XLEN:
  - S = inst[31:25],inst[11:7].
  - B = inst[31],inst[7],inst[30:25],inst[11:8],0.
  - U = inst[31:12],12'b0, sign-extended above bit 31 when XLEN=64.
  - J = inst[31],inst[19:12],inst[20],inst[30:21],0.
  - I = inst[31:20].
- Zero-extended formats:
  - I_star: inst[24:20] when XLEN=32; inst[25:20] when XLEN=64.
  - Z: inst[19:15].
- sel 7: imm = 0 and out_illegal = 1. The entry still flows through the handshake.
- out_target is computed for every format. It is meaningful for B, J and U (auipc). The adder wraps silently.
- Entries leave in strict acceptance order. No entry is dropped or duplicated.
- While out_valid && !out_ready, all out_* signals stay stable.
- flush: every buffered entry is invalidated at the next edge. flush overrides a same-cycle accept, so that input is discarded. A same-cycle consume is harmless.
- reset:
  - out_valid=0, out_imm=0, out_target=0, out_sel=0, out_illegal=0.
  - in_ready=0 while reset is high; in_ready=1 in the first cycle after reset deasserts.
  - Reset mid-stall discards all entries.

## Timing
- Latency: an input accepted at edge N appears with out_valid=1 after edge N (visible in cycle N+1).
- Throughput: 1 entry/cycle while out_ready=1.
- No combinational path from in_* to out_*.
- The in_ready path depends on build configuration; see below.

## Configuration
- IMM_GEN_SKID_EN defined:
  - Two-entry skid buffer (main + skid register).
  - in_ready is a flop, equal to !skid_valid, with no combinational dependence on out_ready.
  - When out_ready falls while the block is accepting, the in-flight input goes into the skid entry.
  - The skid entry drains into main when main is consumed.
- IMM_GEN_SKID_EN undefined:
  - Single output register.
  - in_ready = !reset && (!out_valid || out_ready), combinational.
- Output values, ordering, flush and reset behaviour are identical in both builds.

## Test plan
- B format:
  - Stimulus: inst 0xFE000EE3, sel 1, pc 0x00000100.
  - Required response: out_imm 0xFFFFFFFC, out_target 0x000000FC, one cycle after accept.
- J wrap:
  - Stimulus: inst 0x0040006F, sel 3, pc 0xFFFFFFFC.
  - Required response: out_imm 0x00000004, out_target 0x00000000.
- Shamt and CSR uimm:
  - XLEN=32, inst 0x41F0D093 with sel 5 -> out_imm 31.
  - XLEN=64, inst 0x03F01013 with sel 5 -> out_imm 63.
  - inst 0x000FD073 with sel 6 -> out_imm 31.
- Backpressure:
  - Stimulus: out_ready=0 for 4 cycles while offering 3 back-to-back instructions (sels 4, 0, 2).
  - With skid: in_ready drops after 2 accepts.
  - Without skid: in_ready drops after 1 accept.
  - After out_ready=1, outputs emerge in order with no loss and stay stable while stalled.
- Flush/illegal:
  - flush with in_valid=1, output stalled -> out_valid=0 next cycle and the flushed input never appears.
  - sel 7 -> out_illegal=1, out_imm=0.
- Reset mid-stall:
  - Stimulus: two buffered entries, then reset held for 1 cycle.
  - Required response: all outputs 0, in_ready=0 during reset, then 1; the first new input is delivered correctly.
